// File: rtl/systolic_skew_feeder_if.sv
// Upstream activation-vector handshake into the systolic skew feeder.
// master: vector producer, slave: systolic_skew_feeder.
interface systolic_skew_feeder_if #(
  parameter int unsigned ROWS       = 4,
  parameter int unsigned DATA_WIDTH = 16
);
  logic                       in_valid;
  logic                       in_ready;
  logic [ROWS*DATA_WIDTH-1:0] in_data;
  logic                       in_last;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready
  );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Triangular skew stage feeding the systolic PE array: row r of each accepted
// vector is delayed r cycles, the skew is drained after the last vector of a
// tile and completion is flagged with tile_done.
// Optional: define FEEDER_PERF_CNT_EN to add the stall_cycles counter port.
module systolic_skew_feeder #(
  parameter int unsigned ROWS       = 4,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  systolic_skew_feeder_if.slave      in_bus,
  input  logic                       stall,
  output logic                       pe_enable,
  output logic [ROWS*DATA_WIDTH-1:0] row_data,
  output logic [ROWS-1:0]            row_valid,
  output logic                       busy,
  output logic                       tile_done
`ifdef FEEDER_PERF_CNT_EN
  ,
  output logic [31:0]                stall_cycles
`endif
);

  localparam int unsigned CNT_W = $clog2(ROWS + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] drain_cnt;
  logic             accept;

  // Handshake and array enable are combinational on stall and the state register
  assign pe_enable       = !stall;
  assign in_bus.in_ready = !stall && (state == IDLE || state == STREAM);
  assign accept          = in_bus.in_valid && in_bus.in_ready;

  // Tile sequencing: stream vectors, drain the skew after the last one, pulse done
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      drain_cnt <= '0;
      busy      <= 1'b0;
      tile_done <= 1'b0;
    end else if (!stall) begin
      tile_done <= 1'b0;
      case (state)
        IDLE, STREAM: begin
          if (accept) begin
            if (in_bus.in_last) begin
              if (ROWS == 1) begin
                state     <= DONE;
                busy      <= 1'b0;
                tile_done <= 1'b1;
              end else begin
                state     <= DRAIN;
                busy      <= 1'b1;
                drain_cnt <= CNT_W'(ROWS - 1);
              end
            end else begin
              state <= STREAM;
              busy  <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == CNT_W'(1)) begin
            state     <= DONE;
            drain_cnt <= '0;
            busy      <= 1'b0;
            tile_done <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - CNT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [DATA_WIDTH-1:0] d_q [0:r];
    logic [r:0]            v_q;

    // Row r delay chain of r+1 stages; data holds on bubbles, valid shifts a zero
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int j = 0; j <= r; j++) begin
          d_q[j] <= '0;
        end
        v_q <= '0;
      end else if (!stall) begin
        v_q[0] <= accept;
        if (accept) begin
          d_q[0] <= in_bus.in_data[r*DATA_WIDTH +: DATA_WIDTH];
        end
        for (int j = 1; j <= r; j++) begin
          d_q[j] <= d_q[j-1];
          v_q[j] <= v_q[j-1];
        end
      end
    end

    assign row_data[r*DATA_WIDTH +: DATA_WIDTH] = d_q[r];
    assign row_valid[r]                         = v_q[r];
  end

`ifdef FEEDER_PERF_CNT_EN
  // Saturating count of stalled cycles while a tile is in flight, cleared at completion
  always_ff @(posedge clk) begin
    if (rst || tile_done) begin
      stall_cycles <= '0;
    end else if (stall && busy && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
- Input-side stage directly upstream of the systolic PE array.
- Accepts one ROWS-wide activation vector per cycle over a valid/ready handshake and applies the triangular skew: row r is delayed r cycles. Each PE row's data_in/data_valid_in then arrives aligned with the systolic wavefront.
- Drives the array's global enable from a downstream stall. Drains the skew after the last vector of a tile and flags tile completion.

Parameters:
- ROWS, 4, number of PE rows fed (≥1)
- DATA_WIDTH, 16, activation width; matches the PE data_in width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  upstream vector valid
- in_ready  out  1  feeder can accept a vector this cycle
- in_data  in  ROWS*DATA_WIDTH  vector; row r at bits [r*DATA_WIDTH +: DATA_WIDTH]
- in_last  in  1  qualifies in_data as the final vector of the tile
- stall  in  1  downstream/array back-pressure; freezes the feeder
- pe_enable  out  1  array enable, = !stall (combinational)
- row_data  out  ROWS*DATA_WIDTH  skewed data to PE row inputs, same packing
- row_valid  out  ROWS  per-row data_valid to the PE rows
- busy  out  1  high in STREAM or DRAIN
- tile_done  out  1  one-cycle pulse, coincident with the last valid of the last row

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous, active-high (rst).
- Reset values: row_data=0, row_valid=0, tile_done=0, state=IDLE, drain counter=0, all skew registers and their valids=0. Reset mid-tile discards all in-flight data; no tile_done is produced.
- Accept: occurs when in_valid && in_ready at a rising edge.
  - in_ready = !stall && (state==IDLE || state==STREAM).
- Skew pipeline: row r is a chain of r+1 registers (data plus valid). Register 0 loads the input; it loads valid=0 when no accept occurs.
- Latency: a vector accepted at edge k shows row r on row_data/row_valid[r] after edge k+r.
  - Row 0 is registered, with latency 1 cycle relative to the accept cycle.
- Bubbles: an idle input cycle propagates as row_valid=0 in every row, in skewed order. row_data on invalid slots keeps the shifted (stale) value.
- Stall: while stall=1, every register freezes, including state, drain counter, row_data, row_valid and tile_done. in_ready=0 and pe_enable=0. Outputs resume exactly where they left off when stall falls.
- States:
  - IDLE: busy=0. Accept with in_last=0 → STREAM. Accept with in_last=1 → DRAIN, or → DONE directly when ROWS==1.
  - STREAM: busy=1. Accept with in_last=1 → DRAIN (load drain counter with ROWS-1), or → DONE if ROWS==1. Other accepts stay in STREAM.
  - DRAIN: in_ready=0; the counter decrements on each unstalled edge. Counter reaching 1 → DONE.
  - DONE: one unstalled cycle; tile_done=1, busy=0, in_ready=0 → IDLE.
- tile_done timing: with last accepted at edge k, tile_done is high in the cycle after edge k+ROWS-1, the same cycle as row_valid[ROWS-1] for the last vector. Exactly one cycle, unless stretched by stall.
- in_last without in_valid is ignored. in_valid during DRAIN or DONE is not accepted; upstream holds its data.
- Back-to-back tiles: the next tile may start in the cycle following DONE, so there is a minimum ROWS-cycle gap between tiles.
- Widths: no arithmetic on data; bit-exact passthrough. Drain counter is $clog2(ROWS+1) bits.

Optional Feature:
- Macro: FEEDER_PERF_CNT_EN.
- Defined: adds output port stall_cycles (32 bits).
  - Increments on every cycle with stall=1 && busy=1.
  - Saturates at 0xFFFFFFFF.
  - Clears on rst and on the cycle tile_done is high (that cycle does not count).
- Not defined: port absent, no counter logic.

Test Plan:
- Reset/idle: rst=1 for 2 cycles, then idle → row_valid=0, row_data=0, in_ready=1, busy=0, tile_done=0.
- Skew, ROWS=4: accept vectors V0..V2 back-to-back with row r of Vn = 16'h(n)(r), in_last on V2 at edge k.
  - Row r shows V0,V1,V2 after edges k-2+r, k-1+r, k+r.
  - tile_done high after edge k+3 only; in_ready=0 for 4 cycles after the last accept.
- Bubble: accept V0, idle one cycle, accept V1 (last) → every row shows valid pattern 1,0,1, offset by r.
- Stall: stall=1 for 3 cycles in mid-DRAIN → outputs and tile_done frozen, in_ready=0, pe_enable=0. tile_done arrives exactly 3 cycles later than unstalled.
- Reset mid-tile: rst pulsed in STREAM with 2 vectors in flight → next cycle row_valid=0, state IDLE, no tile_done ever produced for that tile.
- ROWS=1 build: single accept with in_last → row_valid[0] and tile_done both high in the next cycle. With FEEDER_PERF_CNT_EN, 5 stalled busy cycles → stall_cycles=5, cleared at tile_done.
